// File: rtl/mysystem_pio_master.sv
// Purpose: Avalon-MM initiator turning valid/ready commands into PIO register write/read/verify cycles.
// Latency: strobe 1 cycle after accept; response after 2 (write), 2+READ_LATENCY (read), 3+READ_LATENCY (verify).
// Backpressure: one command in flight; cmd_ready low until the response handshakes; bus idle while rsp stalls.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   cmd_*               command stream (valid/ready): write/read select, verify, address, writedata
//   rsp_*               response stream (valid/ready): data (read data or echoed writedata), mismatch
//   avm_*               Avalon-MM PIO slave side: address, chipselect, write_n, writedata, readdata
module mysystem_pio_master #(
    parameter int                ADDR_W       = 2,
    parameter int                DATA_W       = 32,
    parameter int                READ_LATENCY = 0,
    parameter logic [DATA_W-1:0] VERIFY_MASK  = 'h0000_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_verify,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_mismatch,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata
);

    // READ_LATENCY is at most 3, so a 2-bit down-counter covers RWAIT.
    localparam int CNT_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        RSP   = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               verify_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               sample_rd;
    logic               load_rsp;
    logic [DATA_W-1:0]  rsp_data_d;
    logic               rsp_mismatch_d;

    // State register plus registered outputs. Outputs are computed from the
    // next state so that each strobe/valid lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            verify_q       <= 1'b0;
            cnt_q          <= '0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_mismatch   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                avm_address   <= cmd_address;
                avm_writedata <= cmd_writedata;
                verify_q      <= cmd_write && cmd_verify;
            end
            // Loaded on leaving RD so the first RWAIT cycle sees READ_LATENCY.
            if (state_q == RD) begin
                cnt_q <= CNT_W'(READ_LATENCY);
            end else if (state_q == RWAIT) begin
                cnt_q <= cnt_q - 1'b1;
            end
            avm_chipselect <= (state_d == WR) || (state_d == RD);
            avm_write_n    <= (state_d != WR);
            rsp_valid      <= (state_d == RSP);
            if (load_rsp) begin
                rsp_data     <= rsp_data_d;
                rsp_mismatch <= rsp_mismatch_d;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = cmd_write ? WR : RD;
            WR:      state_d = verify_q ? RD : RSP;
            RD:      state_d = (READ_LATENCY == 0) ? RSP : RWAIT;
            RWAIT:   if (cnt_q == CNT_W'(1)) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath decode.
    always_comb begin
        cmd_ready = (state_q == IDLE) && !reset;
        accept    = cmd_valid && cmd_ready;
        // readdata is valid in the RD cycle itself for zero latency,
        // otherwise in the last RWAIT cycle.
        sample_rd = ((state_q == RD) && (READ_LATENCY == 0)) ||
                    ((state_q == RWAIT) && (cnt_q == CNT_W'(1)));
        // Only a write without verify reaches RSP without sampling: echo writedata.
        rsp_data_d     = sample_rd ? avm_readdata : avm_writedata;
        rsp_mismatch_d = sample_rd && verify_q &&
                         (((avm_readdata ^ avm_writedata) & VERIFY_MASK) != '0);
        load_rsp       = (state_d == RSP) && (state_q != RSP);
    end

endmodule
